// File: rtl/led_pattern_sequencer_if.sv
// Control inputs and LED/mode outputs of the LED pattern sequencer.
// The master side drives the tick, mode request and pause; the slave side drives the LEDs.
interface led_pattern_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             tick_in;
    logic             mode_next;
    logic             pause;
    logic [WIDTH-1:0] leds;
    logic [1:0]       mode;
    logic             step_strobe;

    modport master (
        output tick_in, mode_next, pause,
        input  leds, mode, step_strobe
    );

    modport slave (
        input  tick_in, mode_next, pause,
        output leds, mode, step_strobe
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Detects rising edges of a slow tick square wave and steps an LED bank through
// one of four display patterns: SHIFT, BOUNCE, COUNT and BLINK.
module led_pattern_sequencer #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    led_pattern_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] ONE_C       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_C      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_C      = {WIDTH{1'b0}};
    localparam logic [7:0]       HOLD_LAST_C = 8'(HOLD - 1);
    localparam logic             DIR_UP      = 1'b0;
    localparam logic             DIR_DOWN    = 1'b1;

    mode_e            mode_r;
    mode_e            mode_nxt_s;
    logic [WIDTH-1:0] leds_r;
    logic [WIDTH-1:0] leds_nxt_s;
    logic [WIDTH-1:0] pattern_s;
    logic [7:0]       hold_cnt_r;
    logic [7:0]       hold_cnt_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             dir_pat_s;
    logic             strobe_r;
    logic             strobe_nxt_s;
    logic             tick_q_r;
    logic             tick_rise_s;
    logic             step_s;

    assign tick_rise_s = bus.tick_in & ~tick_q_r;
    assign step_s      = tick_rise_s & ~bus.pause & (hold_cnt_r == HOLD_LAST_C);

    // Next LED value and bounce direction for one pattern step in the current mode.
    always_comb begin
        pattern_s = leds_r;
        dir_pat_s = dir_r;
        case (mode_r)
            MODE_SHIFT: begin
                pattern_s = {leds_r[WIDTH-2:0], leds_r[WIDTH-1]};
            end
            MODE_BOUNCE: begin
                // End bits are shown once: reaching an end reverses on the following step.
                if (dir_r == DIR_UP) begin
                    if (leds_r[WIDTH-1]) begin
                        pattern_s = leds_r >> 1;
                        dir_pat_s = DIR_DOWN;
                    end else begin
                        pattern_s = leds_r << 1;
                    end
                end else begin
                    if (leds_r[0]) begin
                        pattern_s = leds_r << 1;
                        dir_pat_s = DIR_UP;
                    end else begin
                        pattern_s = leds_r >> 1;
                    end
                end
            end
            MODE_COUNT: begin
                pattern_s = leds_r + ONE_C;
            end
            MODE_BLINK: begin
                pattern_s = ~leds_r;
            end
            default: begin
                pattern_s = ONE_C;
                dir_pat_s = DIR_UP;
            end
        endcase
    end

    // Mode FSM next state; a mode request overrides any coincident step.
    always_comb begin
        mode_nxt_s     = mode_r;
        leds_nxt_s     = leds_r;
        hold_cnt_nxt_s = hold_cnt_r;
        dir_nxt_s      = dir_r;
        strobe_nxt_s   = 1'b0;
        if (bus.mode_next) begin
            hold_cnt_nxt_s = 8'd0;
            dir_nxt_s      = DIR_UP;
            case (mode_r)
                MODE_SHIFT: begin
                    mode_nxt_s = MODE_BOUNCE;
                    leds_nxt_s = ONE_C;
                end
                MODE_BOUNCE: begin
                    mode_nxt_s = MODE_COUNT;
                    leds_nxt_s = ZERO_C;
                end
                MODE_COUNT: begin
                    mode_nxt_s = MODE_BLINK;
                    leds_nxt_s = ONES_C;
                end
                MODE_BLINK: begin
                    mode_nxt_s = MODE_SHIFT;
                    leds_nxt_s = ONE_C;
                end
                default: begin
                    mode_nxt_s = MODE_SHIFT;
                    leds_nxt_s = ONE_C;
                end
            endcase
        end else if (step_s) begin
            hold_cnt_nxt_s = 8'd0;
            leds_nxt_s     = pattern_s;
            dir_nxt_s      = dir_pat_s;
            strobe_nxt_s   = 1'b1;
        end else if (tick_rise_s && !bus.pause) begin
            hold_cnt_nxt_s = hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
    end

    // State and output registers with synchronous reset; tick history follows tick_in even in reset.
    always_ff @(posedge clock) begin
        tick_q_r <= bus.tick_in;
        if (reset) begin
            mode_r     <= MODE_SHIFT;
            leds_r     <= ONE_C;
            hold_cnt_r <= 8'd0;
            dir_r      <= DIR_UP;
            strobe_r   <= 1'b0;
        end else begin
            mode_r     <= mode_nxt_s;
            leds_r     <= leds_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            dir_r      <= dir_nxt_s;
            strobe_r   <= strobe_nxt_s;
        end
    end

    assign bus.leds        = leds_r;
    assign bus.mode        = mode_r;
    assign bus.step_strobe = strobe_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus pushes expected LED values per step, monitors pop on step_strobe.
// Two instances cover HOLD=1 and HOLD=3.
module tb_led_pattern_sequencer;
    logic clk;
    logic reset;

    led_pattern_sequencer_if #(.WIDTH(8)) if1 ();
    led_pattern_sequencer_if #(.WIDTH(8)) if3 ();

    led_pattern_sequencer #(.WIDTH(8), .HOLD(1)) dut1 (
        .clock (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    led_pattern_sequencer #(.WIDTH(8), .HOLD(3)) dut3 (
        .clock (clk),
        .reset (reset),
        .bus   (if3.slave)
    );

    int         checks;
    int         errors;
    int         strobes1;
    int         strobes3;
    logic [7:0] exp1_q[$];
    logic [7:0] exp3_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the HOLD=1 instance.
    always @(negedge clk) begin
        if (if1.step_strobe === 1'b1) begin
            strobes1++;
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL strobe1_unexpected: leds %0h with no step expected", if1.leds);
            end else begin
                logic [7:0] e;
                e = exp1_q.pop_front();
                if (if1.leds !== e) begin
                    errors++;
                    $display("FAIL step1_leds: got %0h expected %0h", if1.leds, e);
                end
            end
        end
    end

    // Scoreboard monitor for the HOLD=3 instance.
    always @(negedge clk) begin
        if (if3.step_strobe === 1'b1) begin
            strobes3++;
            checks++;
            if (exp3_q.size() == 0) begin
                errors++;
                $display("FAIL strobe3_unexpected: leds %0h with no step expected", if3.leds);
            end else begin
                logic [7:0] e;
                e = exp3_q.pop_front();
                if (if3.leds !== e) begin
                    errors++;
                    $display("FAIL step3_leds: got %0h expected %0h", if3.leds, e);
                end
            end
        end
    end

    // One tick_in rise on dut1; push an expected LED value when a step should result.
    task automatic tick1(input bit expect_step, input logic [7:0] exp);
        @(negedge clk);
        if (expect_step) exp1_q.push_back(exp);
        if1.tick_in = 1'b1;
        @(negedge clk);
        if1.tick_in = 1'b0;
    endtask

    task automatic tick3(input bit expect_step, input logic [7:0] exp);
        @(negedge clk);
        if (expect_step) exp3_q.push_back(exp);
        if3.tick_in = 1'b1;
        @(negedge clk);
        if3.tick_in = 1'b0;
    endtask

    task automatic pulse_mode1();
        @(negedge clk);
        if1.mode_next = 1'b1;
        @(negedge clk);
        if1.mode_next = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] seq2 [9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    logic [7:0] seq3 [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] seq6 [9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    initial begin
        int s0;
        checks = 0; errors = 0; strobes1 = 0; strobes3 = 0;
        reset = 1'b1;
        if1.tick_in = 1'b1; if1.mode_next = 1'b0; if1.pause = 1'b0;
        if3.tick_in = 1'b0; if3.mode_next = 1'b0; if3.pause = 1'b0;

        // Test 1: tick high through reset release gives no edge
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t1_leds", if1.leds, 8'h01);
        chk("t1_mode", if1.mode, 2'd0);
        chk("t1_no_strobe", strobes1, 0);
        if1.tick_in = 1'b0;
        tick1(1'b1, 8'h02);
        @(negedge clk);
        chk("t1_strobes", strobes1, 1);

        // Test 2: SHIFT, 9 rises from 0x01
        do_reset();
        chk("t2_reset_leds", if1.leds, 8'h01);
        s0 = strobes1;
        for (int i = 0; i < 9; i++) tick1(1'b1, seq2[i]);
        @(negedge clk);
        chk("t2_strobes", strobes1 - s0, 9);

        // Test 3: BOUNCE
        pulse_mode1();
        chk("t3_mode", if1.mode, 2'd1);
        chk("t3_leds", if1.leds, 8'h01);
        for (int i = 0; i < 14; i++) tick1(1'b1, seq3[i]);

        // Test 4: COUNT wrap, BLINK, mode_next beats a coincident rise
        pulse_mode1();
        chk("t4_mode_count", if1.mode, 2'd2);
        chk("t4_count_entry", if1.leds, 8'h00);
        for (int i = 1; i <= 256; i++) tick1(1'b1, 8'(i));
        @(negedge clk);
        chk("t4_count_wrap", if1.leds, 8'h00);
        pulse_mode1();
        chk("t4_mode_blink", if1.mode, 2'd3);
        chk("t4_blink_entry", if1.leds, 8'hFF);
        tick1(1'b1, 8'h00);
        @(negedge clk);
        if1.mode_next = 1'b1;
        if1.tick_in   = 1'b1;
        @(negedge clk);
        if1.mode_next = 1'b0;
        if1.tick_in   = 1'b0;
        chk("t4_mode_shift", if1.mode, 2'd0);
        chk("t4_shift_entry", if1.leds, 8'h01);
        chk("t4_strobe_low", if1.step_strobe, 1'b0);

        // Test 6: reset in BOUNCE with dir down at 0x20
        pulse_mode1();
        for (int i = 0; i < 9; i++) tick1(1'b1, seq6[i]);
        do_reset();
        chk("t6_mode", if1.mode, 2'd0);
        chk("t6_leds", if1.leds, 8'h01);
        chk("t6_strobe", if1.step_strobe, 1'b0);
        tick1(1'b1, 8'h02);

        // Test 5: HOLD=3 with pause discarding rises
        tick3(1'b0, 8'h00);
        tick3(1'b0, 8'h00);
        @(negedge clk);
        if3.pause = 1'b1;
        for (int i = 0; i < 5; i++) tick3(1'b0, 8'h00);
        chk("t5_paused_leds", if3.leds, 8'h01);
        chk("t5_no_strobe", strobes3, 0);
        if3.pause = 1'b0;
        tick3(1'b1, 8'h02);
        @(negedge clk);
        chk("t5_strobes", strobes3, 1);
        chk("t5_leds", if3.leds, 8'h02);

        repeat (2) @(negedge clk);
        chk("q1_drained", exp1_q.size(), 0);
        chk("q3_drained", exp3_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
